multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 88 ++++++++
 rtl/multicycle_ctrl_instr_decode.sv | 34 +++
 rtl/multicycle_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS-subset controller: FSM state codes,
// instruction opcode/funct constants, datapath mux encodings and the instruction class.
package multicycle_ctrl_pkg;

  // FSM state codes; 5-7 are illegal and recover to StFetch
  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExe    = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4
  } state_e;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpLb    = 6'b100000;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnJr   = 6'b001000;

  // Register-file write-address select
  localparam logic [2:0] A3Rd = 3'd0;
  localparam logic [2:0] A3Rt = 3'd1;
  localparam logic [2:0] A3Ra = 3'd2;  // $31 for jal

  // Register-file write-data select
  localparam logic [2:0] WdAlu   = 3'd0;
  localparam logic [2:0] WdMem   = 3'd1;
  localparam logic [2:0] WdPc4   = 3'd2;
  localparam logic [2:0] WdMemSb = 3'd3;  // sign-extended byte

  // ALU B-operand select
  localparam logic [2:0] AluBRt  = 3'd0;
  localparam logic [2:0] AluBImm = 3'd1;

  // ALU operation
  localparam logic [1:0] AluAdd = 2'd0;
  localparam logic [1:0] AluSub = 2'd1;
  localparam logic [1:0] AluOr  = 2'd2;
  localparam logic [1:0] AluLui = 2'd3;

  // Next-PC select
  localparam logic [1:0] NpcPc4  = 2'd0;
  localparam logic [1:0] NpcBeq  = 2'd1;
  localparam logic [1:0] NpcJump = 2'd2;
  localparam logic [1:0] NpcRs   = 2'd3;

  // Decoded instruction class
  typedef enum logic [3:0] {
    ClsNop  = 4'd0,
    ClsAddu = 4'd1,
    ClsSubu = 4'd2,
    ClsJr   = 4'd3,
    ClsOri  = 4'd4,
    ClsLui  = 4'd5,
    ClsLw   = 4'd6,
    ClsLb   = 4'd7,
    ClsSw   = 4'd8,
    ClsBeq  = 4'd9,
    ClsJ    = 4'd10,
    ClsJal  = 4'd11
  } instr_class_e;

  // R-type classes write rd; everything else that writes uses rt
  function automatic logic is_rtype(instr_class_e cls);
    return (cls == ClsAddu) || (cls == ClsSubu) || (cls == ClsJr);
  endfunction

  // Instructions that finish in DECODE
  function automatic logic is_decode_only(instr_class_e cls);
    return (cls == ClsNop) || (cls == ClsJ) || (cls == ClsJal) || (cls == ClsJr);
  endfunction

  // Instructions that access data memory
  function automatic logic is_mem(instr_class_e cls);
    return (cls == ClsLw) || (cls == ClsLb) || (cls == ClsSw);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_instr_decode.sv
// Combinational opcode/funct to instruction-class decoder; the only place opcodes are compared.
module instr_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0]   opcode_i,
  input  logic [5:0]   funct_i,
  output instr_class_e cls_o
);

  // Map opcode (and funct for R-type) to a class; unknown encodings become NOP
  always_comb begin
    cls_o = ClsNop;
    case (opcode_i)
      OpRtype: begin
        case (funct_i)
          FnAddu:  cls_o = ClsAddu;
          FnSubu:  cls_o = ClsSubu;
          FnJr:    cls_o = ClsJr;
          default: cls_o = ClsNop;
        endcase
      end
      OpOri:   cls_o = ClsOri;
      OpLui:   cls_o = ClsLui;
      OpLw:    cls_o = ClsLw;
      OpLb:    cls_o = ClsLb;
      OpSw:    cls_o = ClsSw;
      OpBeq:   cls_o = ClsBeq;
      OpJ:     cls_o = ClsJ;
      OpJal:   cls_o = ClsJal;
      default: cls_o = ClsNop;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle controller: FETCH/DECODE/EXE/MEM/WB sequencer driving datapath enables and
// mux selects, plus a retired-instruction counter.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        PCWr,
  output logic        IRWr,
  output logic        RFWr,
  output logic        DMWr,
  output logic [2:0]  RFA3OP,
  output logic [2:0]  RFWDOP,
  output logic [2:0]  ALUBOP,
  output logic [1:0]  ALUOP,
  output logic [1:0]  NPCOP,
  output logic [2:0]  state,
  output logic [31:0] instr_cnt
);

  state_e       state_q, state_d;
  logic [31:0]  cnt_q;
  logic         cnt_en;
  instr_class_e cls;

  // Enables before the reset gate
  logic pc_wr, ir_wr, rf_wr, dm_wr;

  instr_decode u_instr_decode (
    .opcode_i (opcode),
    .funct_i  (funct),
    .cls_o    (cls)
  );

  // Next-state sequencing per instruction class
  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: state_d = is_decode_only(cls) ? StFetch : StExe;
      StExe: begin
        if (cls == ClsBeq) begin
          state_d = StFetch;
        end else if (is_mem(cls)) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem:    state_d = (cls == ClsSw) ? StFetch : StWb;
      StWb:     state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  // Every return to FETCH from elsewhere retires one instruction (NOPs included)
  assign cnt_en = (state_d == StFetch) && (state_q != StFetch);

  // State register and retired-instruction counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (cnt_en) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  // Per-state enables and mux selects; DECODE/EXE outputs depend on the live IR and zero flag,
  // so they are decoded from the current state rather than pre-registered
  always_comb begin
    pc_wr  = 1'b0;
    ir_wr  = 1'b0;
    rf_wr  = 1'b0;
    dm_wr  = 1'b0;
    RFA3OP = A3Rd;
    RFWDOP = WdAlu;
    ALUBOP = AluBRt;
    ALUOP  = AluAdd;
    NPCOP  = NpcPc4;
    case (state_q)
      StFetch: begin
        pc_wr = 1'b1;
        ir_wr = 1'b1;
        NPCOP = NpcPc4;
      end
      StDecode: begin
        case (cls)
          ClsJ: begin
            pc_wr = 1'b1;
            NPCOP = NpcJump;
          end
          ClsJal: begin
            pc_wr  = 1'b1;
            NPCOP  = NpcJump;
            rf_wr  = 1'b1;
            RFA3OP = A3Ra;
            RFWDOP = WdPc4;
          end
          ClsJr: begin
            pc_wr = 1'b1;
            NPCOP = NpcRs;
          end
          default: ;
        endcase
      end
      StExe: begin
        case (cls)
          ClsAddu, ClsSubu, ClsBeq: ALUBOP = AluBRt;
          default:                  ALUBOP = AluBImm;
        endcase
        case (cls)
          ClsSubu, ClsBeq: ALUOP = AluSub;
          ClsOri:          ALUOP = AluOr;
          ClsLui:          ALUOP = AluLui;
          default:         ALUOP = AluAdd;
        endcase
        if (cls == ClsBeq) begin
          pc_wr = zero;
          NPCOP = NpcBeq;
        end
      end
      StMem: begin
        dm_wr = (cls == ClsSw);
      end
      StWb: begin
        rf_wr  = 1'b1;
        RFA3OP = is_rtype(cls) ? A3Rd : A3Rt;
        case (cls)
          ClsLw:   RFWDOP = WdMem;
          ClsLb:   RFWDOP = WdMemSb;
          default: RFWDOP = WdAlu;
        endcase
      end
      default: ;
    endcase
  end

  // Reset holds state at FETCH, so the FETCH enables must be masked while it is low
  assign PCWr = pc_wr & reset;
  assign IRWr = ir_wr & reset;
  assign RFWr = rf_wr & reset;
  assign DMWr = dm_wr & reset;

  assign state     = state_q;
  assign instr_cnt = cnt_q;

endmodule
